// File: rtl/lc3b_types.sv
// Shared LC-3b execute-stage types: data word, multiply/divide opcode and
// the multiply/divide controller state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic {
    MD_MUL,
    MD_DIV
  } lc3b_mdop;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } mdctrl_state_t;

endpackage

// File: rtl/latency_counter.sv
// Loadable 4-bit down-counter with a zero flag; paces the ALU pipeline.
module latency_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic       dec_i,
  input  logic [3:0] load_val_i,
  output logic [3:0] cnt_o,
  output logic       zero_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/mult_div_ctrl.sv
// Sequences one MUL/DIV through the clock-enabled mult_div_alu pipeline,
// stalls EX while busy and short-circuits divide-by-zero.
module mult_div_ctrl
  import lc3b_types::*;
#(
  parameter int unsigned MULT_LAT = 2,
  parameter int unsigned DIV_LAT  = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  lc3b_mdop      op,
  input  lc3b_word      a_in,
  input  lc3b_word      b_in,
  input  logic          flush,
  input  lc3b_word      alu_result,
  output lc3b_word      alu_a,
  output lc3b_word      alu_b,
  output logic          multi_en,
  output logic          div_en,
  output logic          stall,
  output logic          done,
  output lc3b_word      result,
  output logic          dbz,
  output mdctrl_state_t dbg_state
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  // Handshake: start is a level held by EX; it is consumed only in IDLE when
  // flush is low. stall holds EX until the done cycle, when EX may advance.
  mdctrl_state_t state_q, state_d;
  lc3b_mdop      op_q, op_d;
  lc3b_word      alu_a_q, alu_a_d;
  lc3b_word      alu_b_q, alu_b_d;
  lc3b_word      result_q, result_d;
  logic          dbz_q, dbz_d;

  logic          cnt_load;
  logic          cnt_dec;
  logic [3:0]    cnt_load_val;
  logic [3:0]    cnt;
  logic          cnt_zero;

  latency_counter u_latency_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (cnt_load_val),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    result_d     = result_q;
    dbz_d        = dbz_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = MULT_CNT;
    case (state_q)
      MD_IDLE: begin
        if (start && !flush) begin
          alu_a_d = a_in;
          alu_b_d = b_in;
          op_d    = op;
          if ((op == MD_DIV) && (b_in == 16'h0000)) begin
            result_d = 16'h0000;
            dbz_d    = 1'b1;
            state_d  = MD_DONE;
          end else begin
            cnt_load     = 1'b1;
            cnt_load_val = (op == MD_DIV) ? DIV_CNT : MULT_CNT;
            dbz_d        = 1'b0;
            state_d      = MD_BUSY;
          end
        end
      end
      MD_BUSY: begin
        if (flush) begin
          state_d = MD_IDLE;
        end else if (cnt_zero) begin
          result_d = alu_result;
          state_d  = MD_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      MD_DONE: begin
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      op_q     <= MD_MUL;
      alu_a_q  <= 16'h0000;
      alu_b_q  <= 16'h0000;
      result_q <= 16'h0000;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  // div_en stays up through DONE so the ALU output mux does not switch under
  // the captured result; a divide-by-zero never enables the divider.
  assign multi_en  = (state_q == MD_BUSY) && (op_q == MD_MUL);
  assign div_en    = (op_q == MD_DIV) &&
                     ((state_q == MD_BUSY) || ((state_q == MD_DONE) && !dbz_q));
  assign done      = (state_q == MD_DONE);
  assign stall     = ((state_q == MD_IDLE) && start && !flush) || (state_q == MD_BUSY);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign result    = result_q;
  assign dbz       = dbz_q;
  assign dbg_state = state_q;

endmodule
